// File: rtl/button_capture_pkg.sv
// Shared constants for the button capture peripheral.
// Register offsets, limit width and the effective-limit helper.
package button_capture_pkg;

    localparam int LIMIT_WIDTH = 24;

    localparam logic [1:0] REG_STATE = 2'd0;
    localparam logic [1:0] REG_RISE  = 2'd1;
    localparam logic [1:0] REG_FALL  = 2'd2;
    localparam logic [1:0] REG_LIMIT = 2'd3;

    // A programmed limit of zero debounces like a limit of one.
    function automatic logic [LIMIT_WIDTH-1:0] eff_limit(
        input logic [LIMIT_WIDTH-1:0] lim
    );
        return (lim == '0) ? LIMIT_WIDTH'(1) : lim;
    endfunction

endpackage

// File: rtl/button_capture_debounce.sv
// Single-button synchroniser, debounce counter and edge pulses.
// The pulses are combinational and coincide with the state flip.
module button_debounce
    import button_capture_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pin,
    input  logic [LIMIT_WIDTH-1:0] limit,
    output logic                   state,
    output logic                   rise_pulse,
    output logic                   fall_pulse
);

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_state;
    logic [LIMIT_WIDTH-1:0] r_cnt;
    logic [LIMIT_WIDTH:0]   w_cnt_inc;
    logic                   w_mismatch;
    logic                   w_flip;

    // One extra bit so the compare never sees a wrapped count.
    assign w_cnt_inc  = {1'b0, r_cnt} + (LIMIT_WIDTH+1)'(1);
    assign w_mismatch = (r_sync2 != r_state);
    assign w_flip     = w_mismatch &&
                        (w_cnt_inc >= {1'b0, eff_limit(limit)});

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pin;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive mismatches; flip once the limit is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_mismatch) begin
            r_cnt   <= '0;
        end else if (w_flip) begin
            r_state <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= w_cnt_inc[LIMIT_WIDTH-1:0];
        end
    end

    assign state      = r_state;
    assign rise_pulse = w_flip &  r_sync2;
    assign fall_pulse = w_flip & ~r_sync2;

endmodule

// File: rtl/button_capture.sv
// Memory-mapped debounced button block with W1C edge events.
// Zero-wait-state bus slave; read data is zero when unselected.
module button_capture
    import button_capture_pkg::*;
#(
    parameter int BUTTONCOUNT     = 4,
    parameter int DEBOUNCE_CYCLES = 360000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    input  logic [31:0]            address_in,
    input  logic                   sel_in,
    input  logic                   read_in,
    output logic [31:0]            read_value_out,
    input  logic [3:0]             write_mask_in,
    input  logic [31:0]            write_value_in,
    output logic                   ready_out,
    output logic                   irq_out
);

    logic [LIMIT_WIDTH-1:0] r_limit;
    logic [BUTTONCOUNT-1:0] r_rise;
    logic [BUTTONCOUNT-1:0] r_fall;
    logic                   r_irq;
    logic [BUTTONCOUNT-1:0] w_state;
    logic [BUTTONCOUNT-1:0] w_rise_pulse;
    logic [BUTTONCOUNT-1:0] w_fall_pulse;
    logic [BUTTONCOUNT-1:0] w_clr_rise;
    logic [BUTTONCOUNT-1:0] w_clr_fall;
    logic [1:0]             w_offset;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    assign w_offset = address_in[3:2];

    // Reads have no side effects; only the decoded bits matter.
    assign w_unused = ^{read_in, address_in[31:4], address_in[1:0],
                        write_mask_in[3], write_value_in[31:24]};

    for (genvar g = 0; g < BUTTONCOUNT; g++) begin : g_btn
        button_debounce u_deb (
            .clk        (clk),
            .reset      (reset),
            .pin        (buttons_in[g]),
            .limit      (r_limit),
            .state      (w_state[g]),
            .rise_pulse (w_rise_pulse[g]),
            .fall_pulse (w_fall_pulse[g])
        );
    end

    // Write-1-to-clear masks, gated by the low byte enable only.
    always_comb begin
        w_clr_rise = '0;
        w_clr_fall = '0;
        if (sel_in && write_mask_in[0]) begin
            if (w_offset == REG_RISE)
                w_clr_rise = write_value_in[BUTTONCOUNT-1:0];
            if (w_offset == REG_FALL)
                w_clr_fall = write_value_in[BUTTONCOUNT-1:0];
        end
    end

    // Byte-wise writable debounce limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit <= LIMIT_WIDTH'(DEBOUNCE_CYCLES);
        end else if (sel_in && w_offset == REG_LIMIT) begin
            if (write_mask_in[0]) r_limit[7:0]   <= write_value_in[7:0];
            if (write_mask_in[1]) r_limit[15:8]  <= write_value_in[15:8];
            if (write_mask_in[2]) r_limit[23:16] <= write_value_in[23:16];
        end
    end

    // Event latches; a new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_clr_rise) | w_rise_pulse;
            r_fall <= (r_fall & ~w_clr_fall) | w_fall_pulse;
        end
    end

    // Level interrupt, one cycle behind the event registers.
    always_ff @(posedge clk) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= (|r_rise) | (|r_fall);
    end

    // Register read mux, forced to zero when not selected.
    always_comb begin
        w_rdata = '0;
        case (w_offset)
            REG_STATE: w_rdata[BUTTONCOUNT-1:0] = w_state;
            REG_RISE:  w_rdata[BUTTONCOUNT-1:0] = r_rise;
            REG_FALL:  w_rdata[BUTTONCOUNT-1:0] = r_fall;
            default:   w_rdata[LIMIT_WIDTH-1:0] = r_limit;
        endcase
        read_value_out = sel_in ? w_rdata : '0;
    end

    assign ready_out = sel_in;
    assign irq_out   = r_irq;

endmodule

// File: tb/tb_button_capture.sv
// Scoreboard bench for button_capture.
// Reference model judges flips from a window of synchronised samples.
module tb_button_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  buttons_in;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;
    logic        irq_out;

    button_capture dut (
        .clk            (clk),
        .reset          (reset),
        .buttons_in     (buttons_in),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out),
        .irq_out        (irq_out)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    typedef struct packed {
        logic [31:0] exp;
        logic [1:0]  off;
        logic        sel;
    } rd_t;

    rd_t exp_q[$];

    // ---------------- reference model ----------------
    localparam int HMAX = 64;
    bit          hist [4][HMAX];
    int          hv [4];
    logic [3:0]  ms1 = '0, ms2 = '0;
    logic [3:0]  mst = '0, mrise = '0, mfall = '0;
    logic [23:0] mlim = 24'd360000;
    logic        mirq = 1'b0;

    task automatic model_step();
        logic [3:0] set_r, set_f, clr_r, clr_f;
        int L;
        bit all_diff;
        if (reset) begin
            ms1 = '0; ms2 = '0; mst = '0;
            mrise = '0; mfall = '0;
            mlim = 24'd360000; mirq = 1'b0;
            for (int i = 0; i < 4; i++) hv[i] = 0;
            return;
        end
        mirq = (|mrise) | (|mfall);
        L = (mlim == 0) ? 1 : int'(mlim);
        set_r = '0;
        set_f = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = HMAX-1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = ms2[i];
            if (hv[i] < HMAX) hv[i]++;
            // flip when the last L synchronised samples all disagree
            if (L <= hv[i]) begin
                all_diff = 1'b1;
                for (int j = 0; j < L; j++)
                    if (hist[i][j] == mst[i]) all_diff = 1'b0;
                if (all_diff) begin
                    if (mst[i]) set_f[i] = 1'b1;
                    else        set_r[i] = 1'b1;
                    mst[i] = ~mst[i];
                end
            end
        end
        clr_r = '0;
        clr_f = '0;
        if (sel_in && write_mask_in[0] && address_in[3:2] == 2'd1)
            clr_r = write_value_in[3:0];
        if (sel_in && write_mask_in[0] && address_in[3:2] == 2'd2)
            clr_f = write_value_in[3:0];
        mrise = (mrise & ~clr_r) | set_r;
        mfall = (mfall & ~clr_f) | set_f;
        if (sel_in && address_in[3:2] == 2'd3) begin
            if (write_mask_in[0]) mlim[7:0]   = write_value_in[7:0];
            if (write_mask_in[1]) mlim[15:8]  = write_value_in[15:8];
            if (write_mask_in[2]) mlim[23:16] = write_value_in[23:16];
        end
        ms2 = ms1;
        ms1 = buttons_in;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [31:0] mread(input logic [1:0] off);
        case (off)
            2'd0:    return {28'h0, mst};
            2'd1:    return {28'h0, mrise};
            2'd2:    return {28'h0, mfall};
            default: return {8'h0, mlim};
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rd_t e;
        if (!reset) begin
            nvec++;
            if (irq_out !== mirq) begin
                nmis++;
                $display("FAIL irq t=%0t got %b expected %b",
                         $time, irq_out, mirq);
            end
        end
        if (read_in) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nmis++;
                $display("FAIL read t=%0t no expectation queued", $time);
            end else begin
                e = exp_q.pop_front();
                if (read_value_out !== e.exp || ready_out !== e.sel) begin
                    nmis++;
                    $display("FAIL read off=%0d sel=%b t=%0t got %h rdy %b expected %h rdy %b",
                             e.off, e.sel, $time, read_value_out,
                             ready_out, e.exp, e.sel);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        sel_in = 1'b0;
        read_in = 1'b0;
        write_mask_in = 4'h0;
        write_value_in = '0;
        address_in = 32'h0001_0004;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [3:0] mask,
                             input logic [31:0] val);
        sel_in = 1'b1;
        read_in = 1'b0;
        address_in = 32'h0001_0000 | {28'h0, off, 2'b00};
        write_mask_in = mask;
        write_value_in = val;
        tick(1);
        idle();
    endtask

    task automatic bus_read(input logic [1:0] off, input logic sel,
                            input logic [31:0] exp);
        rd_t e;
        e.exp = sel ? exp : 32'h0;
        e.off = off;
        e.sel = sel;
        exp_q.push_back(e);
        sel_in = sel;
        read_in = 1'b1;
        address_in = 32'h0001_0000 | {28'h0, off, 2'b00};
        write_mask_in = 4'h0;
        tick(1);
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] off;
        int op;
        reset = 1'b1;
        buttons_in = 4'h0;
        idle();
        tick(3);
        reset = 1'b0;

        // reset values and sel gating
        bus_read(2'd0, 1'b1, 32'h0);
        bus_read(2'd1, 1'b1, 32'h0);
        bus_read(2'd2, 1'b1, 32'h0);
        bus_read(2'd3, 1'b1, 32'h0005_7E40);
        bus_read(2'd3, 1'b0, 32'h0);

        // limit 5: flip lands 7 cycles after the pin
        bus_write(2'd3, 4'h7, 32'd5);
        buttons_in[1] = 1'b1;
        tick(6);
        bus_read(2'd0, 1'b1, 32'h0);
        bus_read(2'd0, 1'b1, 32'h2);
        bus_read(2'd1, 1'b1, 32'h2);

        // short glitch is ignored
        tick(3);
        buttons_in[2] = 1'b1;
        tick(3);
        buttons_in[2] = 1'b0;
        tick(10);
        bus_read(2'd0, 1'b1, 32'h2);
        bus_read(2'd1, 1'b1, 32'h2);
        bus_read(2'd2, 1'b1, 32'h0);

        // W1C clearing
        buttons_in[0] = 1'b1;
        tick(10);
        bus_read(2'd1, 1'b1, 32'h3);
        bus_write(2'd1, 4'h1, 32'h1);
        bus_read(2'd1, 1'b1, 32'h2);
        bus_write(2'd1, 4'h1, 32'h2);
        bus_read(2'd1, 1'b1, 32'h0);
        tick(2);

        // clear collides with a new rise: set wins
        buttons_in[0] = 1'b0;
        tick(10);
        bus_write(2'd2, 4'h1, 32'h1);
        buttons_in[0] = 1'b1;
        tick(6);
        bus_write(2'd1, 4'h1, 32'h1);
        bus_read(2'd1, 1'b1, 32'h1);

        // limit 0 behaves as 1
        bus_write(2'd3, 4'h7, 32'd0);
        buttons_in[3] = 1'b1;
        tick(6);
        bus_write(2'd1, 4'h1, 32'hF);
        buttons_in[3] = 1'b0;
        tick(2);
        bus_read(2'd0, 1'b1, 32'hB);
        bus_read(2'd0, 1'b1, 32'h3);
        bus_read(2'd2, 1'b1, 32'h8);

        // randomized traffic against the model
        bus_write(2'd3, 4'h7, 32'($urandom_range(0, 6)));
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0)
                buttons_in[$urandom_range(0, 3)] ^= 1'b1;
            op = $urandom_range(0, 9);
            off = 2'($urandom_range(0, 3));
            if (op <= 3) begin
                tick(1);
            end else if (op <= 5) begin
                bus_read(off, ($urandom_range(0, 4) != 0), mread(off));
            end else if (op == 6) begin
                bus_write(2'd1, 4'($urandom), 32'($urandom_range(0, 15)));
            end else if (op == 7) begin
                bus_write(2'd2, 4'($urandom), 32'($urandom_range(0, 15)));
            end else if (op == 8) begin
                bus_write(2'd3, 4'($urandom_range(0, 7)),
                          32'($urandom_range(0, 6)));
            end else begin
                bus_write(2'd0, 4'hF, $urandom);
            end
        end
        tick(12);
        for (int k = 0; k < 4; k++) begin
            off = 2'(k);
            bus_read(off, 1'b1, mread(off));
        end
        tick(2);

        nvec++;
        if (exp_q.size() != 0) begin
            nmis++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
